mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences a single-port 16-bit unified memory shared by two requesters: instruction fetch (IF) and the MEM stage (load/store/push/pop, plus 32-bit PC push/pop for call/ret/rti).
- The MEM stage has priority. 32-bit accesses are split into two 16-bit beats.
- Generates fetch_stall and mem_stall for the pipeline registers.
- Sits between the fetch/memory stages and the memory array.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 12, memory address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- if_req  in  1  fetch requests a word at if_addr.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch access issued to memory this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched word.
- dm_req  in  1  MEM-stage request; held with attributes until dm_done.
- dm_we  in  1  1 = write, 0 = read.
- dm_wide  in  1  1 = 32-bit access (two beats).
- dm_addr  in  ADDR_W  data address (beat 0).
- dm_wdata  in  2*DATA_W  write data; low half is beat 0.
- dm_done  out  1  one-cycle pulse: transaction complete.
- dm_rdata  out  2*DATA_W  read result, valid with dm_done.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after the access.
- fetch_stall  out  1  if_req & ~if_gnt.
- mem_stall  out  1  dm_req & ~dm_done.
- stall_cnt  out  16  fetch-stall counter (see Optional Feature).

Behaviour:
- Memory contract: memory samples mem_* at posedge t. Read data appears on mem_rdata during cycle t+1. At most one access per cycle.
- FSM states:
  - IDLE: no data beat outstanding.
  - DHI: beat 0 outstanding; issue beat 1 this cycle.
  - DLAST: last data beat outstanding; complete the transaction this cycle.
- Transitions:
  - IDLE & dm_req & dm_wide -> DHI.
  - IDLE & dm_req & ~dm_wide -> DLAST.
  - DHI -> DLAST.
  - DLAST -> IDLE.
- Issue rules (combinational mem_* outputs):
  - IDLE & dm_req: issue data beat 0 at addr = dm_addr, wdata = dm_wdata[DATA_W-1:0].
  - DHI: issue beat 1 at addr = dm_addr+1 (mod 2^ADDR_W; 0xFFF wraps to 0x000), wdata = dm_wdata[2*DATA_W-1:DATA_W]. Latch mem_rdata as low half.
  - DLAST: no data issue. dm_done=1; dm_rdata = {mem_rdata, latched low} if wide, {0, mem_rdata} if narrow. Write transactions return dm_rdata=0. This slot is free for fetch.
  - Fetch issues (if_gnt=1, mem_we=0, mem_addr=if_addr) when if_req & ((IDLE & ~dm_req) | DLAST).
- Simultaneous IDLE & dm_req & if_req: data wins; fetch is served in the DLAST slot.
- Back-to-back data requests therefore alternate data/fetch: fetch is never starved.
- if_rvalid: registered if_gnt, so it is high the cycle after if_gnt, with if_rdata = mem_rdata. It may coincide with a data issue.
- Latency:
  - Narrow access: dm_done 1 cycle after issue (mem_stall high 1 cycle).
  - Wide access: dm_done 2 cycles after issue.
- When mem_en=0, mem_we, mem_addr and mem_wdata are 0.
- Reset values: state=IDLE; if_rvalid, dm_done and stall_cnt = 0; rdata latches = 0.
- Reset mid-operation: state aborts to IDLE at once. A wide write may leave only beat 0 written; this is accepted.
- dm_req dropping before dm_done is illegal; behaviour is undefined and not checked.

Optional Feature:
- MEMARB_STALL_CNT_EN defined: stall_cnt is a 16-bit saturating counter of cycles with fetch_stall=1. It saturates at 0xFFFF and is cleared by reset.
- MEMARB_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Fetch only: if_req=1, addrs 0x000..0x003, dm_req=0 -> if_gnt every cycle; if_rvalid one cycle later with mem[addr]; fetch_stall=0.
- Narrow load at 0x010 (mem=0xBEEF) with if_req=1 -> cycle 0: data issue, fetch_stall=1. Cycle 1: dm_done, dm_rdata=0x0000BEEF, if_gnt=1.
- Wide push: dm_we=1, dm_wide=1, addr 0x7FE, wdata 0x12345678 -> mem[0x7FE]=0x5678, mem[0x7FF]=0x1234; dm_done on cycle 2.
- Wide pop at 0xFFF with mem[0xFFF]=0xAAAA, mem[0x000]=0x5555 -> beat 1 addresses 0x000; dm_rdata=0x5555AAAA.
- Reset asserted low during DHI -> state IDLE and dm_done=0 immediately. After release, a new narrow read completes in 1 cycle.
- With MEMARB_STALL_CNT_EN: 3 back-to-back wide accesses with if_req=1 -> stall_cnt=6. Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch and the MEM stage.
// Define MEMARB_STALL_CNT_EN to build the saturating fetch-stall counter.
module mem_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic                dm_wide,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [2*DATA_W-1:0] dm_wdata,
  output logic                dm_done,
  output logic [2*DATA_W-1:0] dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fetch_stall,
  output logic                mem_stall,
  output logic [15:0]         stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DHI   = 2'd1,
    DLAST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= if_gnt;
      // Beat 0 read data is on the bus while beat 1 issues.
      if (state_q == DHI)
        lo_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    dm_done   = 1'b0;
    dm_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d   = dm_wide ? DHI : DLAST;
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata[DATA_W-1:0];
        end else if (if_req) begin
          if_gnt   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = if_addr;
        end
      end
      DHI: begin
        state_d   = DLAST;
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr + 1'b1;
        mem_wdata = dm_wdata[2*DATA_W-1:DATA_W];
      end
      DLAST: begin
        state_d = IDLE;
        dm_done = 1'b1;
        if (!dm_we)
          dm_rdata = dm_wide ? {mem_rdata, lo_q}
                             : {{DATA_W{1'b0}}, mem_rdata};
        // Completion slot carries no data beat, so fetch gets it.
        if (if_req) begin
          if_gnt   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = if_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rvalid   = rvalid_q;
  assign if_rdata    = mem_rdata;
  assign fetch_stall = if_req & ~if_gnt;
  assign mem_stall   = dm_req & ~dm_done;

`ifdef MEMARB_STALL_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (fetch_stall && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
